buraq_rf_writeback: RTL and testbench
=====================================

BURAQ_RF_WRITEBACK -- requirements
Module: buraq_rf_writeback

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of the write-back data.
REQ-002 SHALL have parameter FifoDepth, default 4, number of LSU result entries buffered (power of two, >= 2).
REQ-003 SHALL have parameter StarveLimit, default 8, number of consecutive ALU wins before a waiting FIFO entry is forced through.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  synchronous reset, active high.
REQ-007 alu_valid_i / alu_waddr_i / alu_wdata_i  input  1 / 5 / DataWidth  single-cycle ALU result.
REQ-008 alu_ready_o  output  1  ALU result accepted this cycle.
REQ-009 lsu_valid_i / lsu_waddr_i / lsu_wdata_i  input  1 / 5 / DataWidth  LSU or multi-cycle unit result.
REQ-010 lsu_ready_o  output  1  LSU result accepted into the FIFO this cycle.
REQ-011 we_a_o / waddr_a_o / wdata_a_o  output  1 / 5 / DataWidth  registered register-file write port W1.
REQ-012 raddr_a_i / raddr_b_i  input  5 / 5  decode-stage read addresses R1 / R2.
REQ-013 hazard_a_o / hazard_b_o  output  1 / 1  a pending write targets R1 / R2.
REQ-014 fifo_count_o  output  $clog2(FifoDepth)+1  current number of FIFO entries.

Function
REQ-015 SHALL accept an LSU result on lsu_valid_i && lsu_ready_o and push {waddr, wdata} at that edge.
REQ-016 SHALL drive lsu_ready_o = (fifo_count < FifoDepth), from registered count only; no same-cycle pass-through when full, even if a pop occurs.
REQ-017 SHALL drop, without pushing, any accepted LSU result with waddr == 0; lsu_ready_o still handshakes it.
REQ-018 SHALL arbitrate each cycle: if alu_ready_o && alu_valid_i && alu_waddr_i != 0, the ALU result is the winner; otherwise, if the FIFO is non-empty, the FIFO head is popped as the winner.
REQ-019 SHALL drive alu_ready_o = 1 except when the starve counter equals StarveLimit and the FIFO is non-empty.
REQ-020 SHALL treat an ALU result with waddr 0 as accepted (alu_ready_o rules apply) but produce no write, leaving the FIFO free to win that cycle.
REQ-021 SHALL load the winner into we_a_o / waddr_a_o / wdata_a_o at the edge, giving ALU latency 1: valid in cycle N gives we_a_o in cycle N+1.
REQ-022 SHALL give LSU minimum latency 2: accepted at edge N, popped in cycle N+1, we_a_o asserted in cycle N+2.
REQ-023 SHALL clear we_a_o to 0 in any cycle with no winner; waddr_a_o and wdata_a_o then hold their previous values.
REQ-024 SHALL never assert we_a_o with waddr_a_o == 0.
REQ-025 Starve counter SHALL increment when the ALU wins while the FIFO is non-empty, clear when the FIFO pops or is empty, and saturate at StarveLimit.
REQ-026 SHALL pop and push in the FIFO on the same edge, with count unchanged.
REQ-027 SHALL wrap FIFO read and write pointers modulo FifoDepth.
REQ-028 SHALL write FIFO entries in program order; two entries to the same address SHALL write back in push order.
REQ-029 SHALL assert hazard_x_o when raddr_x_i != 0 and the address matches a valid FIFO entry or the output register while we_a_o = 1.
REQ-030 hazard_x_o SHALL be combinational from the inputs and registered state; it SHALL NOT include an LSU result being handshaken in the same cycle.

Reset
REQ-031 While rst_i = 1 at an edge, SHALL empty the FIFO, clear the starve counter, and set we_a_o = 0, waddr_a_o = 0, wdata_a_o = 0.
REQ-032 After reset, fifo_count_o = 0, hazard_a_o = hazard_b_o = 0, lsu_ready_o = 1 and alu_ready_o = 1.
REQ-033 A reset mid-operation SHALL discard buffered writes without emitting them; handshakes in the reset cycle are ignored.

Verification
REQ-034 ALU valid, waddr 5, wdata 0xA5A5A5A5 at cycle N -> cycle N+1: we_a_o = 1, waddr_a_o = 5, wdata_a_o = 0xA5A5A5A5; cycle N+2: we_a_o = 0.
REQ-035 LSU pushes to x3 = 0x11, x4 = 0x22, ALU idle -> writes x3 then x4 on consecutive cycles starting 2 cycles after the first push; fifo_count_o returns to 0.
REQ-036 Push 4 LSU entries with ALU busy -> lsu_ready_o = 0 with fifo_count_o = 4; after 8 ALU wins alu_ready_o = 0 for one cycle and the FIFO head is written.
REQ-037 LSU entry to x7 buffered, raddr_a_i = 7, raddr_b_i = 0 -> hazard_a_o = 1, hazard_b_o = 0, until the cycle after x7 is written.
REQ-038 ALU and LSU writes to x0 -> no we_a_o pulse and no FIFO growth.
REQ-039 rst_i = 1 with 3 entries buffered -> next cycle fifo_count_o = 0, we_a_o = 0, and no buffered write ever appears.

Source files
------------

// File: rtl/buraq_rf_writeback.sv
// Register-file write-back arbiter: merges single-cycle ALU results with a FIFO of
// LSU results onto one write port and flags read-after-write hazards for decode.
module buraq_rf_writeback #(
    parameter int DataWidth   = 32,
    parameter int FifoDepth   = 4,
    parameter int StarveLimit = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         alu_valid_i,
    input  logic [4:0]                   alu_waddr_i,
    input  logic [DataWidth-1:0]         alu_wdata_i,
    output logic                         alu_ready_o,
    input  logic                         lsu_valid_i,
    input  logic [4:0]                   lsu_waddr_i,
    input  logic [DataWidth-1:0]         lsu_wdata_i,
    output logic                         lsu_ready_o,
    output logic                         we_a_o,
    output logic [4:0]                   waddr_a_o,
    output logic [DataWidth-1:0]         wdata_a_o,
    input  logic [4:0]                   raddr_a_i,
    input  logic [4:0]                   raddr_b_i,
    output logic                         hazard_a_o,
    output logic                         hazard_b_o,
    output logic [$clog2(FifoDepth):0]   fifo_count_o
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;
    localparam int StvW = $clog2(StarveLimit + 1);

    logic [4:0]           fifo_addr_q [FifoDepth];
    logic [DataWidth-1:0] fifo_data_q [FifoDepth];
    logic [PtrW-1:0]      rd_ptr_q;
    logic [PtrW-1:0]      wr_ptr_q;
    logic [CntW-1:0]      count_q;
    logic [StvW-1:0]      starve_q;

    logic fifo_empty;
    logic alu_win;
    logic pop;
    logic push;
    logic hit_a;
    logic hit_b;
    logic [PtrW-1:0] idx;

    assign fifo_empty   = (count_q == '0);
    assign alu_ready_o  = !((starve_q == StvW'(StarveLimit)) && !fifo_empty);
    assign lsu_ready_o  = (count_q < CntW'(FifoDepth));
    assign alu_win      = alu_ready_o && alu_valid_i && (alu_waddr_i != 5'd0);
    // An ALU write to x0 is consumed without claiming the port, so the FIFO may drain.
    assign pop          = !alu_win && !fifo_empty;
    assign push         = lsu_valid_i && lsu_ready_o && (lsu_waddr_i != 5'd0);
    assign fifo_count_o = count_q;

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx   = '0;
        for (int k = 0; k < FifoDepth; k++) begin
            idx = rd_ptr_q + PtrW'(k);
            if (CntW'(k) < count_q) begin
                if (fifo_addr_q[idx] == raddr_a_i) hit_a = 1'b1;
                if (fifo_addr_q[idx] == raddr_b_i) hit_b = 1'b1;
            end
        end
    end

    assign hazard_a_o = (raddr_a_i != 5'd0) && (hit_a || (we_a_o && (waddr_a_o == raddr_a_i)));
    assign hazard_b_o = (raddr_b_i != 5'd0) && (hit_b || (we_a_o && (waddr_a_o == raddr_b_i)));

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            fifo_addr_q[wr_ptr_q] <= lsu_waddr_i;
            fifo_data_q[wr_ptr_q] <= lsu_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || fifo_empty || pop) begin
            starve_q <= '0;
        end else if (alu_win && (starve_q != StvW'(StarveLimit))) begin
            starve_q <= starve_q + StvW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_a_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
        end else if (alu_win) begin
            we_a_o    <= 1'b1;
            waddr_a_o <= alu_waddr_i;
            wdata_a_o <= alu_wdata_i;
        end else if (pop) begin
            we_a_o    <= 1'b1;
            waddr_a_o <= fifo_addr_q[rd_ptr_q];
            wdata_a_o <= fifo_data_q[rd_ptr_q];
        end else begin
            we_a_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_buraq_rf_writeback.sv
// Bench for buraq_rf_writeback: queue-based reference model feeding a write-back
// scoreboard, with directed scenarios followed by randomized traffic.
module tb_buraq_rf_writeback;

    localparam int Depth = 4;
    localparam int Limit = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_waddr_i = '0;
    logic [31:0] alu_wdata_i = '0;
    logic        alu_ready_o;
    logic        lsu_valid_i = 1'b0;
    logic [4:0]  lsu_waddr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        lsu_ready_o;
    logic        we_a_o;
    logic [4:0]  waddr_a_o;
    logic [31:0] wdata_a_o;
    logic [4:0]  raddr_a_i = '0;
    logic [4:0]  raddr_b_i = '0;
    logic        hazard_a_o;
    logic        hazard_b_o;
    logic [2:0]  fifo_count_o;

    buraq_rf_writeback #(.DataWidth(32), .FifoDepth(Depth), .StarveLimit(Limit)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .alu_ready_o(alu_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_ready_o(lsu_ready_o),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o),
        .fifo_count_o(fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_valid = 0;

    // Reference model: pending LSU writes in order, starvation count, last write.
    logic [4:0]  mq_addr [$];
    logic [31:0] mq_data [$];
    int          starve = 0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    logic [4:0]  sb_addr [$];
    logic [31:0] sb_data [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit haz(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        if (m_we && m_addr == ra) return 1'b1;
        foreach (mq_addr[i]) if (mq_addr[i] == ra) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk_i) begin
        if (model_valid && we_a_o === 1'b1) begin
            if (sb_addr.size() == 0) begin
                chk("wb_unexpected", {27'd0, waddr_a_o}, 32'hFFFF_FFFF);
            end else begin
                chk("wb_addr", {27'd0, waddr_a_o}, {27'd0, sb_addr.pop_front()});
                chk("wb_data", wdata_a_o, sb_data.pop_front());
            end
        end
    end

    task automatic step(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] ra, input logic [4:0] rb);
        bit a_rdy, l_rdy, a_win;
        @(negedge clk_i);
        rst_i = r; alu_valid_i = av; alu_waddr_i = aa; alu_wdata_i = ad;
        lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
        raddr_a_i = ra; raddr_b_i = rb;
        #1;
        a_rdy = !(starve == Limit && mq_addr.size() > 0);
        l_rdy = mq_addr.size() < Depth;
        if (model_valid) begin
            chk("alu_ready",  {31'd0, alu_ready_o}, {31'd0, a_rdy});
            chk("lsu_ready",  {31'd0, lsu_ready_o}, {31'd0, l_rdy});
            chk("fifo_count", {29'd0, fifo_count_o}, mq_addr.size());
            chk("hazard_a",   {31'd0, hazard_a_o}, {31'd0, haz(ra)});
            chk("hazard_b",   {31'd0, hazard_b_o}, {31'd0, haz(rb)});
            chk("we_a",       {31'd0, we_a_o}, {31'd0, m_we});
            chk("waddr_a",    {27'd0, waddr_a_o}, {27'd0, m_addr});
            chk("wdata_a",    wdata_a_o, m_data);
        end
        if (r) begin
            mq_addr.delete(); mq_data.delete();
            starve = 0; m_we = 0; m_addr = '0; m_data = '0;
            model_valid = 1;
        end else if (model_valid) begin
            a_win = a_rdy && av && aa != 5'd0;
            if (a_win) begin
                m_we = 1; m_addr = aa; m_data = ad;
                starve = (mq_addr.size() > 0) ? ((starve < Limit) ? starve + 1 : Limit) : 0;
            end else if (mq_addr.size() > 0) begin
                m_we = 1; m_addr = mq_addr.pop_front(); m_data = mq_data.pop_front();
                starve = 0;
            end else begin
                m_we = 0; starve = 0;
            end
            if (m_we) begin
                sb_addr.push_back(m_addr);
                sb_data.push_back(m_data);
            end
            if (lv && l_rdy && la != 5'd0) begin
                mq_addr.push_back(la);
                mq_data.push_back(ld);
            end
        end
    endtask

    task automatic idle(input int n, input logic [4:0] ra = 5'd0);
        for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, ra, 5'd0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Single ALU write, latency one.
        step(0, 1, 5'd5, 32'hA5A5_A5A5, 0, 0, 0, 0, 0);
        idle(3);

        // Two LSU writes drain in order when the ALU is idle.
        step(0, 0, 0, 0, 1, 5'd3, 32'h11, 0, 0);
        step(0, 0, 0, 0, 1, 5'd4, 32'h22, 0, 0);
        idle(4);

        // Fill the FIFO under continuous ALU traffic until starvation forces a pop.
        for (int i = 0; i < 14; i++)
            step(0, 1, 5'(10 + (i % 8)), 32'h1000 + i, 1, 5'(20 + (i % 4)), 32'h2000 + i, 5'd20, 5'd10);
        idle(8);

        // Hazard tracking on a buffered x7 write.
        step(0, 1, 5'd9, 32'h99, 1, 5'd7, 32'h77, 5'd7, 5'd0);
        step(0, 1, 5'd9, 32'h98, 0, 0, 0, 5'd7, 5'd0);
        idle(4, 5'd7);

        // Writes to x0 from both sources.
        step(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 0, 0);
        idle(3);

        // Reset with buffered entries discards them.
        for (int i = 0; i < 3; i++)
            step(0, 1, 5'd12, 32'h300 + i, 1, 5'(24 + i), 32'h400 + i, 5'd24, 5'd25);
        step(1, 1, 5'd13, 32'h500, 1, 5'd27, 32'h600, 5'd24, 5'd25);
        idle(6, 5'd24);

        // Randomized traffic with varying ALU pressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int busy;
            bit av, lv, r;
            logic [4:0] aa, la;
            busy = ((i / 200) % 2 == 0) ? 90 : 40;
            av = ($urandom_range(99) < busy);
            lv = ($urandom_range(99) < 50);
            aa = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            la = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            r  = ($urandom_range(299) == 0);
            step(r, av, aa, $urandom, lv, la, $urandom,
                 5'($urandom_range(7)), 5'($urandom_range(7)));
        end
        idle(12);
        chk("sb_drain", sb_addr.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
